mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/common.svh | 7 +
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/common.svh
// Shared width definitions for the memory subsystem.
`ifndef COMMON_SVH
`define COMMON_SVH
`define ADDR_WIDTH 16
`define DATA_WIDTH 8
`define WORD_WIDTH 32
`endif

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises 1-4 byte big-endian word
// transfers onto a byte-wide memory with combinational read data.
`include "common.svh"

module mem_arbiter (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_p0_req,
  input  logic [`ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [1:0]             i_p0_len,
  output logic [`WORD_WIDTH-1:0] o_p0_rdata,
  output logic                   o_p0_done,
  input  logic                   i_p1_req,
  input  logic                   i_p1_we,
  input  logic [`ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [1:0]             i_p1_len,
  input  logic [`WORD_WIDTH-1:0] i_p1_wdata,
  output logic [`WORD_WIDTH-1:0] o_p1_rdata,
  output logic                   o_p1_done,
  output logic [`ADDR_WIDTH-1:0] o_mem_addr,
  output logic [`DATA_WIDTH-1:0] o_mem_data,
  output logic                   o_mem_write,
  input  logic [`DATA_WIDTH-1:0] i_mem_data,
  output logic                   o_busy,
  output logic                   o_owner
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             cnt;
  logic                   last_owner;
  logic [`ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]             lat_len;
  logic                   lat_we;
  logic [`WORD_WIDTH-1:0] lat_wdata;
  logic [`WORD_WIDTH-1:0] shadow;
  logic [`WORD_WIDTH-1:0] byte_word;
  logic                   elig0, elig1, grant, grant_port, last_byte;
  logic [4:0]             shift;

  always_comb begin
    elig0      = i_p0_req && !o_p0_done;
    elig1      = i_p1_req && !o_p1_done;
    grant      = 1'b0;
    grant_port = 1'b0;
    state_nxt  = state;
    last_byte  = (cnt == lat_len);
    if (state == IDLE) begin
      if (elig0 || elig1) begin
        grant      = 1'b1;
        grant_port = (elig0 && elig1) ? ~last_owner : elig1;
        state_nxt  = XFER;
      end
    end else if (last_byte) begin
      state_nxt = IDLE;
    end
  end

  // Byte cnt of an L-byte word sits at bit offset (L-1-cnt)*8.
  always_comb begin
    shift       = {lat_len - cnt, 3'b000};
    byte_word   = `WORD_WIDTH'(i_mem_data) << shift;
    o_busy      = (state == XFER);
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_data  = '0;
    if (state == XFER) begin
      o_mem_write = lat_we;
      o_mem_addr  = lat_addr + {{(`ADDR_WIDTH-2){1'b0}}, cnt};
      o_mem_data  = lat_we ? lat_wdata[shift +: 8] : '0;
    end
  end

  // Read bytes gather in a shadow word so rdata only changes when a read completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      o_owner    <= 1'b0;
      o_p0_done  <= 1'b0;
      o_p1_done  <= 1'b0;
      o_p0_rdata <= '0;
      o_p1_rdata <= '0;
      lat_addr   <= '0;
      lat_len    <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      shadow     <= '0;
    end else begin
      state     <= state_nxt;
      o_p0_done <= 1'b0;
      o_p1_done <= 1'b0;
      if (grant) begin
        lat_addr   <= grant_port ? i_p1_addr : i_p0_addr;
        lat_len    <= grant_port ? i_p1_len : i_p0_len;
        lat_we     <= grant_port ? i_p1_we : 1'b0;
        lat_wdata  <= grant_port ? i_p1_wdata : '0;
        cnt        <= '0;
        o_owner    <= grant_port;
        last_owner <= grant_port;
        shadow     <= '0;
      end else if (state == XFER) begin
        cnt <= cnt + 2'd1;
        if (!lat_we) shadow <= shadow | byte_word;
        if (last_byte) begin
          if (o_owner) begin
            o_p1_done <= 1'b1;
            if (!lat_we) o_p1_rdata <= shadow | byte_word;
          end else begin
            o_p0_done <= 1'b1;
            if (!lat_we) o_p0_rdata <= shadow | byte_word;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: byte memory model, latency,
// endianness, address wrap, round-robin and asynchronous-reset abort.
module tb_mem_arbiter;

  localparam int AW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_p0_req;
  logic [AW-1:0] i_p0_addr;
  logic [1:0]    i_p0_len;
  logic [31:0]   o_p0_rdata;
  logic          o_p0_done;
  logic          i_p1_req;
  logic          i_p1_we;
  logic [AW-1:0] i_p1_addr;
  logic [1:0]    i_p1_len;
  logic [31:0]   i_p1_wdata;
  logic [31:0]   o_p1_rdata;
  logic          o_p1_done;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_data;
  logic          o_mem_write;
  logic [7:0]    i_mem_data;
  logic          o_busy;
  logic          o_owner;

  logic [7:0] mem [0:65535];
  assign i_mem_data = mem[o_mem_addr];

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] addr_log[$];
  logic [23:0]   wr_log[$];
  int            checks = 0;
  int            errors = 0;

  mem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_p0_req(i_p0_req), .i_p0_addr(i_p0_addr), .i_p0_len(i_p0_len),
    .o_p0_rdata(o_p0_rdata), .o_p0_done(o_p0_done),
    .i_p1_req(i_p1_req), .i_p1_we(i_p1_we), .i_p1_addr(i_p1_addr),
    .i_p1_len(i_p1_len), .i_p1_wdata(i_p1_wdata),
    .o_p1_rdata(o_p1_rdata), .o_p1_done(o_p1_done),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_write(o_mem_write),
    .i_mem_data(i_mem_data), .o_busy(o_busy), .o_owner(o_owner)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer on one port; done must arrive L+1 cycles after the grant edge.
  task automatic apply_stimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                input logic [1:0] len, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input string tag);
    exp_t e;
    int   lat;
    int   obs_port;
    addr_log.delete();
    wr_log.delete();
    @(negedge i_clk);
    if (port == 0) begin
      i_p0_req = 1'b1; i_p0_addr = addr; i_p0_len = len;
    end else begin
      i_p1_req = 1'b1; i_p1_we = we; i_p1_addr = addr; i_p1_len = len; i_p1_wdata = wdata;
    end
    sb.push_back('{port, exp_rdata});
    @(posedge i_clk);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge i_clk);
      if (o_busy) begin
        addr_log.push_back(o_mem_addr);
        if (o_mem_write) begin
          wr_log.push_back({o_mem_addr, o_mem_data});
          mem[o_mem_addr] = o_mem_data;
        end
      end
      if (o_p0_done || o_p1_done) begin
        lat = n;
        obs_port = o_p1_done ? 1 : 0;
        e = sb.pop_front();
        check_output({tag, "_port"}, obs_port, e.port);
        check_output({tag, "_rdata"}, obs_port == 1 ? o_p1_rdata : o_p0_rdata, e.rdata);
      end
      if (n == 1) begin
        i_p0_req = 1'b0; i_p1_req = 1'b0;
        i_p0_addr = '1; i_p1_addr = '1; i_p1_wdata = '1;
      end
    end
    check_output({tag, "_latency"}, lat, int'(len) + 2);
    check_output({tag, "_writes"}, wr_log.size(), we ? int'(len) + 1 : 0);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    int          order[$];
    int          run0, run1, max_run, wr_after, done_after;
    logic [31:0] p1_before;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0040] = 8'h5A;
    mem[16'hFFFF] = 8'hA1; mem[16'h0000] = 8'hB2; mem[16'h0001] = 8'hC3; mem[16'h0002] = 8'hD4;
    i_rst = 1'b1;
    i_p0_req = 1'b0; i_p0_addr = '0; i_p0_len = '0;
    i_p1_req = 1'b0; i_p1_we = 1'b0; i_p1_addr = '0; i_p1_len = '0; i_p1_wdata = '0;

    #12;
    check_output("rst_busy", o_busy, 0);
    check_output("rst_owner", o_owner, 0);
    check_output("rst_p0_done", o_p0_done, 0);
    check_output("rst_p1_done", o_p1_done, 0);
    check_output("rst_p0_rdata", o_p0_rdata, 0);
    check_output("rst_p1_rdata", o_p1_rdata, 0);
    check_output("rst_mem_write", o_mem_write, 0);
    check_output("rst_mem_addr", o_mem_addr, 0);
    check_output("rst_mem_data", o_mem_data, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    apply_stimulus(0, 1'b0, 16'h0010, 2'd3, 32'h0, 32'h11223344, "p0_read4");
    check_output("p0_read4_addr0", addr_log[0], 16'h0010);
    check_output("p0_read4_addr3", addr_log[3], 16'h0013);
    check_output("p0_read4_owner", o_owner, 0);

    apply_stimulus(1, 1'b0, 16'h0040, 2'd0, 32'h0, 32'h0000005A, "p1_read1");
    check_output("p1_read1_owner", o_owner, 1);

    p1_before = 32'h0000005A;
    apply_stimulus(1, 1'b1, 16'h0020, 2'd1, 32'h0000ABCD, p1_before, "p1_write2");
    check_output("p1_write2_byte0", wr_log[0], 24'h0020AB);
    check_output("p1_write2_byte1", wr_log[1], 24'h0021CD);
    check_output("p1_write2_mem_idle", o_mem_write, 0);

    apply_stimulus(0, 1'b0, 16'hFFFF, 2'd3, 32'h0, 32'hA1B2C3D4, "p0_wrap");
    check_output("p0_wrap_nbytes", addr_log.size(), 4);
    check_output("p0_wrap_a0", addr_log[0], 16'hFFFF);
    check_output("p0_wrap_a1", addr_log[1], 16'h0000);
    check_output("p0_wrap_a2", addr_log[2], 16'h0001);
    check_output("p0_wrap_a3", addr_log[3], 16'h0002);

    // Both ports hammer continuously from the first cycle after reset.
    pulse_reset();
    i_p0_req = 1'b1; i_p0_addr = 16'h0010; i_p0_len = 2'd0;
    i_p1_req = 1'b1; i_p1_we = 1'b0; i_p1_addr = 16'h0040; i_p1_len = 2'd0;
    run0 = 0; run1 = 0; max_run = 0;
    for (int n = 0; n < 40 && order.size() < 3; n++) begin
      @(negedge i_clk);
      run0 = o_p0_done ? run0 + 1 : 0;
      run1 = o_p1_done ? run1 + 1 : 0;
      if (run0 > max_run) max_run = run0;
      if (run1 > max_run) max_run = run1;
      if (o_p0_done) order.push_back(0);
      if (o_p1_done) order.push_back(1);
    end
    i_p0_req = 1'b0; i_p1_req = 1'b0;
    check_output("rr_count", order.size(), 3);
    check_output("rr_first", order[0], 0);
    check_output("rr_second", order[1], 1);
    check_output("rr_third", order[2], 0);
    check_output("rr_done_width", max_run, 1);
    check_output("rr_p0_rdata", o_p0_rdata, 32'h00000011);
    check_output("rr_p1_rdata", o_p1_rdata, 32'h0000005A);
    repeat (4) @(negedge i_clk);

    // Asynchronous reset in the middle of a 4-byte write.
    i_p1_req = 1'b1; i_p1_we = 1'b1; i_p1_addr = 16'h0050; i_p1_len = 2'd3; i_p1_wdata = 32'h01020304;
    @(posedge i_clk);
    @(negedge i_clk);
    i_p1_req = 1'b0;
    check_output("abort_c0_data", o_mem_data, 8'h01);
    @(negedge i_clk);
    check_output("abort_c1_write", o_mem_write, 1);
    check_output("abort_c1_addr", o_mem_addr, 16'h0051);
    check_output("abort_c1_data", o_mem_data, 8'h02);
    #1 i_rst = 1'b1;
    #1;
    check_output("abort_mem_write", o_mem_write, 0);
    check_output("abort_busy", o_busy, 0);
    check_output("abort_mem_addr", o_mem_addr, 0);
    check_output("abort_p0_rdata", o_p0_rdata, 0);
    check_output("abort_p1_rdata", o_p1_rdata, 0);
    #1 i_rst = 1'b0;
    wr_after = 0; done_after = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      if (o_mem_write) wr_after++;
      if (o_p0_done || o_p1_done) done_after++;
    end
    check_output("abort_no_writes", wr_after, 0);
    check_output("abort_no_done", done_after, 0);
    apply_stimulus(0, 1'b0, 16'h0010, 2'd0, 32'h0, 32'h00000011, "post_abort");
    check_output("post_abort_owner", o_owner, 0);
    check_output("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
